seq_detector_param: RTL and testbench

//   Parametrised serial pattern detector. Monitors a 1-bit stream and flags each

---
 rtl/seq_detector_param.sv | 80 ++++++++
 tb/tb_seq_detector_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial PAT_W-bit pattern detector with overlap select, valid qualifier and saturating hit counter.
// z is registered (1-cycle latency); define SEQDET_MEALY_EN for combinational z in the final-bit cycle.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t           state;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nxt;
  // Oldest history bit is never compared: the incoming x completes the window.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] window;
  logic             hit;

  assign window = {hist, x};
  assign hit    = x_valid && (fill >= LAST) && (window == pattern);

  always_comb begin
    fill_nxt = fill;
    if (x_valid) begin
      if (hit)
        fill_nxt = overlap ? FULL : '0;
      else if (state != ARMED)
        fill_nxt = fill + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fill      <= '0;
      hist      <= '0;
      match_cnt <= '0;
    end else begin
      fill <= fill_nxt;
      if (fill_nxt == '0)
        state <= IDLE;
      else if (fill_nxt == FULL)
        state <= ARMED;
      else
        state <= FILL;
      if (x_valid)
        hist <= window[PAT_W-2:0];
      // Clear wins over a coincident hit.
      if (clr_cnt)
        match_cnt <= '0;
      else if (hit && !(&match_cnt))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

`ifdef SEQDET_MEALY_EN
  assign z = hit & rst;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      z <= 1'b0;
    else
      z <= hit;
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a PAT_W=4/CNT_W=2 instance and a PAT_W=2 instance
// share one input stream; z is judged per bit (pre-edge for the Mealy build, post-edge otherwise).
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       x;
  logic       x_valid;
  logic       overlap;
  logic       clr_cnt;
  logic [3:0] pat4;
  logic [1:0] pat2;
  logic       z4;
  logic       z2;
  logic [1:0] cnt4;
  logic [7:0] cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut4 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pattern(pat4),
    .overlap(overlap), .clr_cnt(clr_cnt), .z(z4), .match_cnt(cnt4)
  );

  seq_detector_param #(.PAT_W(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pattern(pat2),
    .overlap(overlap), .clr_cnt(clr_cnt), .z(z2), .match_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: drive at negedge, return the z value that belongs to this bit.
  task automatic step(input logic b, input logic v, input logic clr,
                      output logic z4o, output logic z2o);
    logic zc4, zc2;
    @(negedge clk);
    x = b; x_valid = v; clr_cnt = clr;
    #1;
    zc4 = z4; zc2 = z2;
    @(posedge clk);
    #1;
`ifdef SEQDET_MEALY_EN
    z4o = zc4; z2o = zc2;
`else
    z4o = z4;  z2o = z2;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; x_valid = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (z4 !== 1'b0) begin n_fail++; $display("FAIL reset_z4: got %b want 0", z4); end
    n_checks++; if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt4: got %0d want 0", cnt4); end
    n_checks++; if (z2 !== 1'b0) begin n_fail++; $display("FAIL reset_z2: got %b want 0", z2); end
    n_checks++; if (cnt2 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt2: got %0d want 0", cnt2); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_overlap();
    logic [5:0] bits, ez;
    logic z4o, z2o;
    do_reset();
    overlap = 1'b1;
    bits = 6'b101010; ez = 6'b000101;
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1, 1'b0, z4o, z2o);
      n_checks++;
      if (z4o !== ez[5-i]) begin n_fail++; $display("FAIL overlap_z bit%0d: got %b want %b", i+1, z4o, ez[5-i]); end
    end
    step(1'b0, 1'b0, 1'b0, z4o, z2o);
    n_checks++; if (z4o !== 1'b0) begin n_fail++; $display("FAIL overlap_idle_z: got %b want 0", z4o); end
    n_checks++; if (cnt4 !== 2'd2) begin n_fail++; $display("FAIL overlap_cnt: got %0d want 2", cnt4); end
  endtask

  task automatic test_non_overlap();
    logic [9:0] bits, ez;
    logic z4o, z2o;
    do_reset();
    overlap = 1'b0;
    bits = 10'b1010101010; ez = 10'b0001000100;
    for (int i = 0; i < 10; i++) begin
      step(bits[9-i], 1'b1, 1'b0, z4o, z2o);
      n_checks++;
      if (z4o !== ez[9-i]) begin n_fail++; $display("FAIL nonovl_z bit%0d: got %b want %b", i+1, z4o, ez[9-i]); end
      if (i == 5) begin
        n_checks++; if (cnt4 !== 2'd1) begin n_fail++; $display("FAIL nonovl_cnt_mid: got %0d want 1", cnt4); end
      end
    end
    n_checks++; if (cnt4 !== 2'd2) begin n_fail++; $display("FAIL nonovl_cnt: got %0d want 2", cnt4); end
  endtask

  task automatic test_valid_gaps();
    logic [5:0] bits, ez;
    logic z4o, z2o;
    do_reset();
    overlap = 1'b1;
    bits = 6'b101010; ez = 6'b000101;
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1, 1'b0, z4o, z2o);
      n_checks++;
      if (z4o !== ez[5-i]) begin n_fail++; $display("FAIL gaps_z bit%0d: got %b want %b", i+1, z4o, ez[5-i]); end
      // The idle bit carries junk that must be ignored.
      step(~bits[5-i], 1'b0, 1'b0, z4o, z2o);
      n_checks++;
      if (z4o !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_z bit%0d: got %b want 0", i+1, z4o); end
    end
    n_checks++; if (cnt4 !== 2'd2) begin n_fail++; $display("FAIL gaps_cnt: got %0d want 2", cnt4); end
  endtask

  task automatic test_saturate_clear();
    logic [3:0] bits, ez;
    int ec[5] = '{1, 2, 3, 3, 3};
    logic z4o, z2o;
    do_reset();
    overlap = 1'b0;
    bits = 4'b1010; ez = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) begin
        step(bits[3-i], 1'b1, 1'b0, z4o, z2o);
        n_checks++;
        if (z4o !== ez[3-i]) begin n_fail++; $display("FAIL sat_z match%0d bit%0d: got %b want %b", k+1, i+1, z4o, ez[3-i]); end
      end
      n_checks++;
      if (cnt4 !== 2'(ec[k])) begin n_fail++; $display("FAIL sat_cnt match%0d: got %0d want %0d", k+1, cnt4, ec[k]); end
    end
    for (int i = 0; i < 3; i++) step(bits[3-i], 1'b1, 1'b0, z4o, z2o);
    step(1'b0, 1'b1, 1'b1, z4o, z2o);
    n_checks++; if (z4o !== 1'b1) begin n_fail++; $display("FAIL clr_hit_z: got %b want 1", z4o); end
    n_checks++; if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL clr_hit_cnt: got %0d want 0", cnt4); end
    step(1'b0, 1'b0, 1'b0, z4o, z2o);
    n_checks++; if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL clr_hold_cnt: got %0d want 0", cnt4); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] pre;
    logic [6:0] bits, ez;
    logic z4o, z2o;
    do_reset();
    overlap = 1'b1;
    pre = 3'b101;
    for (int i = 0; i < 3; i++) step(pre[2-i], 1'b1, 1'b0, z4o, z2o);
    do_reset();
    n_checks++; if (cnt4 !== 2'd0) begin n_fail++; $display("FAIL rstmid_cnt0: got %0d want 0", cnt4); end
    bits = 7'b0101010; ez = 7'b0000101;
    for (int i = 0; i < 7; i++) begin
      step(bits[6-i], 1'b1, 1'b0, z4o, z2o);
      n_checks++;
      if (z4o !== ez[6-i]) begin n_fail++; $display("FAIL rstmid_z bit%0d: got %b want %b", i+1, z4o, ez[6-i]); end
    end
    n_checks++; if (cnt4 !== 2'd2) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 2", cnt4); end
  endtask

  task automatic test_pat2();
    logic [5:0] bits, ez;
    logic z4o, z2o;
    do_reset();
    overlap = 1'b1;
    bits = 6'b110010; ez = 6'b001001;
    for (int i = 0; i < 6; i++) begin
      step(bits[5-i], 1'b1, 1'b0, z4o, z2o);
      n_checks++;
      if (z2o !== ez[5-i]) begin n_fail++; $display("FAIL pat2_z bit%0d: got %b want %b", i+1, z2o, ez[5-i]); end
    end
    n_checks++; if (cnt2 !== 8'd2) begin n_fail++; $display("FAIL pat2_cnt: got %0d want 2", cnt2); end
  endtask

  initial begin
    rst = 1'b0; x = 1'b0; x_valid = 1'b0; overlap = 1'b1; clr_cnt = 1'b0;
    pat4 = 4'b1010; pat2 = 2'b10;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_saturate_clear();
    test_reset_mid();
    test_pat2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
